fdpe_pipe: RTL and testbench
============================

Name: fdpe_pipe

Overview:
- Parametrised clocked successor to the single-bit preset latch/flop models in the Verilator-compatible Xilinx primitive library.
- Provides a WIDTH-bit, DEPTH-stage register pipeline with:
  - clock enable;
  - per-bit synchronous set mask;
  - valid tracking;
  - flush;
  - optional data gating.
- Used where RTL instantiates chains of FDPE/FDRE primitives, so that one model replaces WIDTH×DEPTH single-bit instances in simulation.

Parameters:
- WIDTH, 8: data width in bits, 1..64.
- DEPTH, 3: number of register stages (latency), 1..16. Out-of-range values raise an $error at elaboration.
- INIT, {WIDTH{1'b0}}: value of every stage at time zero, before any reset.
- RST_VAL, {WIDTH{1'b0}}: value loaded into every stage data register by the asynchronous reset.
- GATE_DATA, 0:
  - 0: stage data shifts on every enabled edge.
  - 1: a stage data register loads only when its incoming valid is 1.

Ports:
- C  input  1  clock, rising edge active.
- RST_N  input  1  asynchronous reset, active low.
- CE  input  1  clock enable for data and valid shift.
- FLUSH  input  1  synchronous clear of all valid bits.
- VLD_I  input  1  input data valid.
- D  input  WIDTH  data in.
- SET  input  WIDTH  per-bit synchronous preset mask applied at stage 0.
- Q  output  WIDTH  data out (last stage).
- VLD_O  output  1  valid of last stage.
- BUSY  output  1  OR of all stage valid bits.

Behaviour:
- Storage: stage data s[0..DEPTH-1] (WIDTH bits each) and valid v[0..DEPTH-1].
  - Q = s[DEPTH-1].
  - VLD_O = v[DEPTH-1].
  - BUSY = |v.
- Time zero: s[k] = INIT and v[k] = 0 for all k.
- Reset (RST_N = 0, asynchronous):
  - Takes effect immediately, with no clock needed: s[k] = RST_VAL, v[k] = 0.
  - Result: Q = RST_VAL, VLD_O = 0, BUSY = 0.
  - Held while RST_N is low; clock edges are ignored.
- Reset release: the first rising C with RST_N = 1 performs normal operation. No synchronisation is inside the block.
- Rising C, RST_N = 1, CE = 1, FLUSH = 0:
  - s[0] <= D | SET; v[0] <= VLD_I.
  - For k ≥ 1: s[k] <= s[k-1]; v[k] <= v[k-1].
- Latency: data presented with VLD_I = 1 appears on Q with VLD_O = 1 exactly DEPTH enabled edges later.
- CE = 0 and FLUSH = 0: all s and v hold. D, SET and VLD_I are ignored.
- FLUSH = 1 (independent of CE):
  - All v <= 0, including the slot for the incoming VLD_I.
  - If CE = 1, data still shifts as above. If CE = 0, data holds.
  - BUSY = 0 on the cycle after the flush edge.
- GATE_DATA = 1:
  - s[0] loads only if VLD_I = 1; s[k] loads only if v[k-1] = 1. Otherwise s[k] holds.
  - Valid bits shift normally.
  - SET still applies only when s[0] loads.
- SET: a bitwise OR at capture. SET bits with D = 0 force 1. SET has no effect on stages ≥ 1.
- Simultaneous events: RST_N = 0 overrides everything. FLUSH overrides VLD_I. CE gates only the data and valid shift, not the flush.
- DEPTH = 1: a single register stage; BUSY equals VLD_O.

Optional Feature:
- Macro: FDPE_PIPE_OCC_EN.
- Defined:
  - Adds an output port OCC, width $clog2(DEPTH+1), equal to the population count of v[0..DEPTH-1].
  - OCC is combinational from the registers, is 0 in reset, and is 0 the cycle after FLUSH.
- Undefined: no OCC port and no count logic. All other behaviour is identical.

Test Plan (WIDTH=8, DEPTH=3, RST_VAL=8'hA5, INIT=8'h00 unless stated):
- Time zero / reset: check Q=8'h00 before reset. Assert RST_N=0 mid-cycle, without a clock edge, after loading data → Q=8'hA5, VLD_O=0, BUSY=0 immediately. Release, then one edge with D=8'h11, VLD_I=1 → v[0]=1.
- Latency: CE=1, D=8'h3C with VLD_I=1 for 1 cycle, then VLD_I=0 → Q=8'h3C and VLD_O=1 on exactly the 3rd edge, for 1 cycle. BUSY=1 for 3 cycles.
- Set mask and CE: D=8'h00, SET=8'h81, VLD_I=1 → Q=8'h81 after 3 edges. CE=0 for 2 cycles mid-flight stretches the latency to 5 edges, with the value unchanged.
- Flush: feed valid 8'h01, 8'h02, 8'h03 back-to-back, then FLUSH=1 with VLD_I=1, D=8'h04 on the 4th edge → VLD_O=0, BUSY=0 after that edge, with no valid output ever for 8'h04. Repeat with CE=0: the flush still clears and Q holds.
- GATE_DATA=1: valid 8'h55, then 2 invalid cycles with D=8'hFF → Q stays 8'h55 after it arrives, and the stages never take 8'hFF.
- FDPE_PIPE_OCC_EN defined: 2 valid inputs then idle → OCC sequence 1,2,2,1,0. FLUSH at OCC=2 → OCC=0 the next cycle.

Source files
------------

// File: rtl/fdpe_pipe.sv
// fdpe_pipe: WIDTH x DEPTH register pipeline that replaces chains of FDPE/FDRE flops.
// Optional occupancy count output OCC is enabled by defining FDPE_PIPE_OCC_EN.
module fdpe_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] INIT      = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] RST_VAL   = {WIDTH{1'b0}},
  parameter int               GATE_DATA = 0
) (
  input  logic             C,
  input  logic             RST_N,
  input  logic             CE,
  input  logic             FLUSH,
  input  logic             VLD_I,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] SET,
  output logic [WIDTH-1:0] Q,
  output logic             VLD_O,
  output logic             BUSY
`ifdef FDPE_PIPE_OCC_EN
  , output logic [$clog2(DEPTH+1)-1:0] OCC
`endif
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("fdpe_pipe: WIDTH %0d outside 1..64", WIDTH);
  end
  if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
    $error("fdpe_pipe: DEPTH %0d outside 1..16", DEPTH);
  end

  // Declaration initialisers model the primitive's power-up value before any reset.
  logic [DEPTH-1:0][WIDTH-1:0] r_s = {DEPTH{INIT}};
  logic [DEPTH-1:0]            r_v = '0;

  always_ff @(posedge C or negedge RST_N) begin
    if (!RST_N) begin
      r_s <= {DEPTH{RST_VAL}};
      r_v <= '0;
    end else begin
      // With gating, a stage only captures when the valid bit travelling with it is set.
      if (CE) begin
        if ((GATE_DATA == 0) || VLD_I) begin
          r_s[0] <= D | SET;
        end
        for (int k = 1; k < DEPTH; k++) begin
          if ((GATE_DATA == 0) || r_v[k-1]) begin
            r_s[k] <= r_s[k-1];
          end
        end
      end
      if (FLUSH) begin
        r_v <= '0;
      end else if (CE) begin
        r_v[0] <= VLD_I;
        for (int k = 1; k < DEPTH; k++) begin
          r_v[k] <= r_v[k-1];
        end
      end
    end
  end

  assign Q     = r_s[DEPTH-1];
  assign VLD_O = r_v[DEPTH-1];
  assign BUSY  = |r_v;

`ifdef FDPE_PIPE_OCC_EN
  localparam int OW = $clog2(DEPTH+1);
  logic [OW-1:0] w_occ;

  always_comb begin
    w_occ = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_occ = w_occ + OW'(r_v[k]);
    end
  end

  assign OCC = w_occ;
`endif

endmodule

// File: tb/tb_fdpe_pipe.sv
// Bench for fdpe_pipe: ungated and gated instances driven in parallel, checked against
// an edge-history model; OCC checks follow FDPE_PIPE_OCC_EN.
module tb_fdpe_pipe;
  localparam int         W   = 8;
  localparam int         DEP = 3;
  localparam logic [7:0] RV  = 8'hA5;

  logic       C = 1'b0, RST_N = 1'b1, CE = 1'b0, FLUSH = 1'b0, VLD_I = 1'b0;
  logic [7:0] D = '0, SET = '0;
  logic [7:0] q0, q1;
  logic       vo0, vo1, b0, b1;
`ifdef FDPE_PIPE_OCC_EN
  logic [1:0] occ0, occ1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // History model: every edge's flush flag, and every enabled edge's capture.
  bit         fl_q[$];
  logic [7:0] e_dat[$];
  bit         e_vld[$];
  int         e_edge[$];

  always #5 C = ~C;

  fdpe_pipe #(.WIDTH(W), .DEPTH(DEP), .INIT(8'h00), .RST_VAL(RV), .GATE_DATA(0)) u_dut (
    .C(C), .RST_N(RST_N), .CE(CE), .FLUSH(FLUSH), .VLD_I(VLD_I), .D(D), .SET(SET),
    .Q(q0), .VLD_O(vo0), .BUSY(b0)
`ifdef FDPE_PIPE_OCC_EN
    , .OCC(occ0)
`endif
  );

  fdpe_pipe #(.WIDTH(W), .DEPTH(DEP), .INIT(8'h00), .RST_VAL(RV), .GATE_DATA(1)) u_dut_gate (
    .C(C), .RST_N(RST_N), .CE(CE), .FLUSH(FLUSH), .VLD_I(VLD_I), .D(D), .SET(SET),
    .Q(q1), .VLD_O(vo1), .BUSY(b1)
`ifdef FDPE_PIPE_OCC_EN
    , .OCC(occ1)
`endif
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit flush_in(input int a, input int b);
    for (int j = a; j < b; j++) if (fl_q[j]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit ent_valid(input int idx);
    return e_vld[idx] && !flush_in(e_edge[idx], fl_q.size());
  endfunction

  function automatic logic [7:0] exp_q(input bit gate);
    int m = e_dat.size();
    if (!gate) return (m >= DEP) ? e_dat[m-DEP] : RV;
    // Gated: newest item that reached the last stage with its valid never flushed en route.
    for (int idx = m - DEP; idx >= 0; idx--) begin
      if (e_vld[idx] && !flush_in(e_edge[idx], e_edge[idx+DEP-1])) return e_dat[idx];
    end
    return RV;
  endfunction

  function automatic int exp_occ();
    int m = e_dat.size();
    int n = 0;
    for (int i = (m > DEP ? m - DEP : 0); i < m; i++) if (ent_valid(i)) n++;
    return n;
  endfunction

  function automatic bit exp_vld();
    int m = e_dat.size();
    return (m >= DEP) ? ent_valid(m - DEP) : 1'b0;
  endfunction

  task automatic check_all();
    check_val("q",        q0,  exp_q(1'b0));
    check_val("q_gate",   q1,  exp_q(1'b1));
    check_val("vld_o",    vo0, exp_vld());
    check_val("vld_gate", vo1, exp_vld());
    check_val("busy",     b0,  exp_occ() != 0);
    check_val("busy_gate", b1, exp_occ() != 0);
`ifdef FDPE_PIPE_OCC_EN
    check_val("occ",      occ0, exp_occ());
    check_val("occ_gate", occ1, exp_occ());
`endif
  endtask

  task automatic clear_model();
    fl_q.delete(); e_dat.delete(); e_vld.delete(); e_edge.delete();
  endtask

  task automatic tick(input bit ce, input bit fl, input bit vi, input logic [7:0] d,
                      input logic [7:0] set, input bit chk);
    CE = ce; FLUSH = fl; VLD_I = vi; D = d; SET = set;
    @(posedge C);
    fl_q.push_back(fl);
    if (ce) begin
      e_dat.push_back(d | set);
      e_vld.push_back(vi && !fl);
      e_edge.push_back(fl_q.size() - 1);
    end
    #1;
    if (chk) check_all();
  endtask

  task automatic drain();
    for (int i = 0; i < DEP + 1; i++) tick(1, 0, 0, 8'h00, 8'h00, 1);
  endtask

  initial begin
    #1;
    check_val("init_q", q0, 8'h00);
    check_val("init_q_gate", q1, 8'h00);

    // Load something, then reset mid-cycle with no clock edge.
    tick(1, 0, 1, 8'h77, 8'h00, 0);
    tick(1, 0, 1, 8'h66, 8'h00, 0);
    #3 RST_N = 1'b0;
    #1;
    check_val("rst_q", q0, RV);
    check_val("rst_q_gate", q1, RV);
    check_val("rst_vld", vo0, 1'b0);
    check_val("rst_busy", b0, 1'b0);
    clear_model();
    @(posedge C); #1;
    check_val("rst_hold_q", q0, RV);
    #3 RST_N = 1'b1;
    tick(1, 0, 1, 8'h11, 8'h00, 1);
    check_val("post_rst_busy", b0, 1'b1);
    drain();

    // Latency: one valid item, visible for exactly one cycle on the 3rd edge.
    tick(1, 0, 1, 8'h3C, 8'h00, 1);
    check_val("lat_busy1", b0, 1'b1);
    for (int i = 2; i <= 4; i++) begin
      tick(1, 0, 0, 8'h00, 8'h00, 1);
      check_val("lat_vld", vo0, i == 3);
      check_val("lat_busy", b0, i <= 3);
      if (i == 3) check_val("lat_q", q0, 8'h3C);
    end

    // Set mask with two CE-low cycles mid-flight.
    tick(1, 0, 1, 8'h00, 8'h81, 1);
    tick(1, 0, 0, 8'h00, 8'h00, 1);
    tick(0, 0, 1, 8'hEE, 8'hFF, 1);
    tick(0, 0, 1, 8'hEE, 8'hFF, 1);
    check_val("set_vld_early", vo0, 1'b0);
    tick(1, 0, 0, 8'h00, 8'h00, 1);
    check_val("set_q", q0, 8'h81);
    check_val("set_vld", vo0, 1'b1);
    drain();

    // Flush with CE=1, then with CE=0.
    tick(1, 0, 1, 8'h01, 8'h00, 1);
    tick(1, 0, 1, 8'h02, 8'h00, 1);
    tick(1, 0, 1, 8'h03, 8'h00, 1);
    tick(1, 1, 1, 8'h04, 8'h00, 1);
    check_val("flush_vld", vo0, 1'b0);
    check_val("flush_busy", b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0, 8'h00, 8'h00, 1);
      check_val("flush_no_04", vo0, 1'b0);
    end
    tick(1, 0, 1, 8'h01, 8'h00, 1);
    tick(1, 0, 1, 8'h02, 8'h00, 1);
    tick(1, 0, 1, 8'h03, 8'h00, 1);
    tick(0, 1, 1, 8'h04, 8'h00, 1);
    check_val("flush_ce0_q", q0, 8'h01);
    check_val("flush_ce0_busy", b0, 1'b0);
    drain();

    // Gated instance: 8'h55 arrives and stays; 8'hFF never enters.
    tick(1, 0, 1, 8'h55, 8'h00, 1);
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, 0, 8'hFF, 8'h00, 1);
      if (i >= 1) check_val("gate_q", q1, 8'h55);
    end
    check_val("ungated_q", q0, 8'hFF);

`ifdef FDPE_PIPE_OCC_EN
    begin
      int occ_seq[5] = '{1, 2, 2, 1, 0};
      for (int i = 0; i < 5; i++) begin
        tick(1, 0, i < 2, 8'h20 + 8'(i), 8'h00, 1);
        check_val("occ_seq", occ0, occ_seq[i]);
      end
      tick(1, 0, 1, 8'h30, 8'h00, 1);
      tick(1, 0, 1, 8'h31, 8'h00, 1);
      check_val("occ_pre_flush", occ0, 2);
      tick(1, 1, 0, 8'h00, 8'h00, 1);
      check_val("occ_flush", occ0, 0);
    end
`endif

    // Randomised traffic against the history model.
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)),
           8'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
